// File: rtl/axis_snooper_pkg.sv
// Shared definitions for the AXI-Stream snooper: FSM encoding, byte-increment
// width derivation and the buffer-full address constant.
package axis_snooper_pkg;

    typedef enum logic [1:0] {
        ST_SYNC    = 2'd0,
        ST_IDLE    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DROP    = 2'd3
    } sn_state_e;

    // Width needed to hold a byte count from 0 up to the full lane count.
    function automatic int calc_inc_width(input int data_width);
        return $clog2(data_width / 8) + 1;
    endfunction

    // Address of the last word in a 2^addr_width buffer.
    function automatic int calc_addr_full(input int addr_width);
        return (32'sd1 << addr_width) - 32'sd1;
    endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational TKEEP byte counter: number of set lanes in the keep mask.
module keep_popcount #(
    parameter int LANES = 8,
    parameter int CNT_W = $clog2(LANES) + 1
) (
    input  logic [LANES-1:0] keep,
    output logic [CNT_W-1:0] cnt
);

    // Sum every keep lane into the byte count.
    always_comb begin
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            cnt = cnt + CNT_W'(keep[i]);
        end
    end

endmodule

// File: rtl/axis_snooper.sv
// Passive AXI-Stream tap turning each accepted packet into word-addressed writes.
// Optional macro SN_DROP_COUNT_EN adds a saturating count of packets dropped from IDLE.
module axis_snooper
    import axis_snooper_pkg::*;
#(
    parameter int SN_FWD_DATA_WIDTH = 64,
    parameter int SN_FWD_ADDR_WIDTH = 9,
    parameter int INC_WIDTH         = calc_inc_width(SN_FWD_DATA_WIDTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SN_FWD_DATA_WIDTH-1:0]   sn_TDATA,
    input  logic [SN_FWD_DATA_WIDTH/8-1:0] sn_TKEEP,
    input  logic                           sn_TVALID,
    input  logic                           sn_TREADY,
    input  logic                           sn_TLAST,
    input  logic                           ready_for_sn,
`ifdef SN_DROP_COUNT_EN
    output logic [31:0]                    sn_drop_cnt,
`endif
    output logic [SN_FWD_ADDR_WIDTH-1:0]   sn_addr,
    output logic [SN_FWD_DATA_WIDTH-1:0]   sn_wr_data,
    output logic                           sn_wr_en,
    output logic [INC_WIDTH-1:0]           sn_byte_inc,
    output logic                           sn_done,
    output logic                           sn_trunc
);

    localparam int KEEP_W = SN_FWD_DATA_WIDTH / 8;
    localparam logic [SN_FWD_ADDR_WIDTH-1:0] ADDR_FULL =
        SN_FWD_ADDR_WIDTH'(calc_addr_full(SN_FWD_ADDR_WIDTH));
    localparam logic [SN_FWD_ADDR_WIDTH-1:0] ADDR_ONE = SN_FWD_ADDR_WIDTH'(1);

    sn_state_e                    state_r, state_nxt_s;
    logic [SN_FWD_ADDR_WIDTH-1:0] addr_cnt_r, addr_nxt_s, cur_addr_s, wr_addr_s;
    logic                         full_r, full_nxt_s, cur_full_s;
    logic                         trunc_r, trunc_nxt_s, cur_trunc_s;
    logic                         acc_s, keep_nz_s, capture_s, write_s, done_s, drop_pkt_s;
    logic [INC_WIDTH-1:0]         keep_cnt_s;

    assign acc_s     = sn_TVALID & sn_TREADY;
    assign keep_nz_s = |sn_TKEEP;

    keep_popcount #(
        .LANES (KEEP_W),
        .CNT_W (INC_WIDTH)
    ) u_keep_popcount (
        .keep (sn_TKEEP),
        .cnt  (keep_cnt_s)
    );

    // Next-state and capture datapath; IDLE starts every packet from a clean buffer.
    always_comb begin
        state_nxt_s = state_r;
        addr_nxt_s  = addr_cnt_r;
        full_nxt_s  = full_r;
        trunc_nxt_s = trunc_r;
        cur_addr_s  = addr_cnt_r;
        cur_full_s  = full_r;
        cur_trunc_s = trunc_r;
        wr_addr_s   = addr_cnt_r;
        capture_s   = 1'b0;
        write_s     = 1'b0;
        done_s      = 1'b0;
        drop_pkt_s  = 1'b0;

        case (state_r)
            ST_SYNC: begin
                if (acc_s && sn_TLAST) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_IDLE: begin
                cur_addr_s  = {SN_FWD_ADDR_WIDTH{1'b0}};
                cur_full_s  = 1'b0;
                cur_trunc_s = 1'b0;
                if (acc_s && ready_for_sn) begin
                    capture_s   = 1'b1;
                    state_nxt_s = sn_TLAST ? ST_IDLE : ST_CAPTURE;
                end else if (acc_s) begin
                    drop_pkt_s  = sn_TLAST;
                    state_nxt_s = sn_TLAST ? ST_IDLE : ST_DROP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_CAPTURE: begin
                if (acc_s) begin
                    capture_s   = 1'b1;
                    state_nxt_s = sn_TLAST ? ST_IDLE : ST_CAPTURE;
                end else begin
                    state_nxt_s = ST_CAPTURE;
                end
            end
            ST_DROP: begin
                if (acc_s && sn_TLAST) begin
                    drop_pkt_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_SYNC;
            end
        endcase

        // The counter parks on the last word once it is written; later data only sets trunc.
        if (capture_s) begin
            addr_nxt_s  = cur_addr_s;
            full_nxt_s  = cur_full_s;
            trunc_nxt_s = cur_trunc_s;
            wr_addr_s   = cur_addr_s;
            done_s      = sn_TLAST;
            if (keep_nz_s && !cur_full_s) begin
                write_s = 1'b1;
                if (cur_addr_s == ADDR_FULL) begin
                    full_nxt_s = 1'b1;
                end else begin
                    addr_nxt_s = cur_addr_s + ADDR_ONE;
                end
            end else if (keep_nz_s) begin
                trunc_nxt_s = 1'b1;
            end else begin
                trunc_nxt_s = cur_trunc_s;
            end
        end else begin
            done_s = 1'b0;
        end
    end

    // FSM and per-packet buffer bookkeeping; cleared on every entry to IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_SYNC;
            addr_cnt_r <= {SN_FWD_ADDR_WIDTH{1'b0}};
            full_r     <= 1'b0;
            trunc_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_nxt_s == ST_IDLE) begin
                addr_cnt_r <= {SN_FWD_ADDR_WIDTH{1'b0}};
                full_r     <= 1'b0;
                trunc_r    <= 1'b0;
            end else begin
                addr_cnt_r <= addr_nxt_s;
                full_r     <= full_nxt_s;
                trunc_r    <= trunc_nxt_s;
            end
        end
    end

    // Registered write port; address/data/increment hold between writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            sn_addr     <= {SN_FWD_ADDR_WIDTH{1'b0}};
            sn_wr_data  <= {SN_FWD_DATA_WIDTH{1'b0}};
            sn_wr_en    <= 1'b0;
            sn_byte_inc <= {INC_WIDTH{1'b0}};
            sn_done     <= 1'b0;
            sn_trunc    <= 1'b0;
        end else begin
            sn_wr_en <= write_s;
            sn_done  <= done_s;
            sn_trunc <= done_s & trunc_nxt_s;
            if (write_s) begin
                sn_addr     <= wr_addr_s;
                sn_wr_data  <= sn_TDATA;
                sn_byte_inc <= keep_cnt_s;
            end
        end
    end

`ifdef SN_DROP_COUNT_EN
    // Saturating count of whole packets dropped for lack of a buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            sn_drop_cnt <= 32'd0;
        end else if (drop_pkt_s && (sn_drop_cnt != 32'hFFFF_FFFF)) begin
            sn_drop_cnt <= sn_drop_cnt + 32'd1;
        end
    end
`endif

endmodule
